// File: rtl/moment_divider.sv
// Signed fixed-point divider: ux = pux / p and uy = puy / p, computed in parallel by radix-2
// restoring division with a shared divisor and iteration counter.
//
// state  | meaning
// IDLE   | waiting for div_start
// LOAD   | form signs, magnitudes and shifted dividends, clear accumulators
// ITER   | one restoring-division step per cycle, N cycles
// FINISH | saturate, apply sign, register results
// DONE   | div_valid pulse; a new div_start chains straight into LOAD
module moment_divider #(
    parameter int DATA_WIDTH = 64,
    parameter int FRAC_BITS  = 32
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         div_start,
    input  logic signed [DATA_WIDTH-1:0] pux,
    input  logic signed [DATA_WIDTH-1:0] puy,
    input  logic signed [DATA_WIDTH-1:0] p,
    output logic signed [DATA_WIDTH-1:0] ux_quot,
    output logic signed [DATA_WIDTH-1:0] uy_quot,
    output logic                         div_valid,
    output logic                         div_busy,
    output logic                         div_by_zero
);
    localparam int DW    = DATA_WIDTH;
    localparam int N     = DATA_WIDTH + FRAC_BITS;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FINISH, S_DONE} state_t;

    state_t           state;
    logic [DW-1:0]    op_x, op_y, op_p, mag_p;
    logic             sx, sy, zero_flag;
    logic [N-1:0]     dvd_x, dvd_y, quot_x, quot_y;
    logic [DW-1:0]    rem_x, rem_y;
    logic [CNT_W-1:0] cnt;
    logic [DW:0]      trial_x, trial_y;
    logic [DW-1:0]    rem_x_nxt, rem_y_nxt;
    logic             ge_x, ge_y;

    function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v);
        return v[DW-1] ? (~v + 1'b1) : v;
    endfunction

    // Symmetric saturation to +/-(2^(DW-1)-1), then sign applied (truncation toward zero).
    function automatic logic [DW-1:0] apply_sign(input logic [N-1:0] q, input logic s);
        logic [DW-1:0] m;
        m = (|q[N-1:DW-1]) ? {1'b0, {(DW-1){1'b1}}} : q[DW-1:0];
        return s ? (~m + 1'b1) : m;
    endfunction

    // The remainder is always below |p| <= 2^(DW-1) after a step, so DW bits hold it;
    // only the shifted trial value needs the extra bit.
    always_comb begin
        trial_x   = {rem_x, dvd_x[N-1]};
        trial_y   = {rem_y, dvd_y[N-1]};
        ge_x      = trial_x >= {1'b0, mag_p};
        ge_y      = trial_y >= {1'b0, mag_p};
        rem_x_nxt = ge_x ? DW'(trial_x - {1'b0, mag_p}) : trial_x[DW-1:0];
        rem_y_nxt = ge_y ? DW'(trial_y - {1'b0, mag_p}) : trial_y[DW-1:0];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= S_IDLE;
            op_x        <= '0;
            op_y        <= '0;
            op_p        <= '0;
            mag_p       <= '0;
            sx          <= 1'b0;
            sy          <= 1'b0;
            zero_flag   <= 1'b0;
            dvd_x       <= '0;
            dvd_y       <= '0;
            quot_x      <= '0;
            quot_y      <= '0;
            rem_x       <= '0;
            rem_y       <= '0;
            cnt         <= '0;
            ux_quot     <= '0;
            uy_quot     <= '0;
            div_valid   <= 1'b0;
            div_busy    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            div_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (div_start) begin
                        op_x     <= pux;
                        op_y     <= puy;
                        op_p     <= p;
                        div_busy <= 1'b1;
                        state    <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    sx        <= op_x[DW-1] ^ op_p[DW-1];
                    sy        <= op_y[DW-1] ^ op_p[DW-1];
                    mag_p     <= magnitude(op_p);
                    dvd_x     <= {magnitude(op_x), {FRAC_BITS{1'b0}}};
                    dvd_y     <= {magnitude(op_y), {FRAC_BITS{1'b0}}};
                    rem_x     <= '0;
                    rem_y     <= '0;
                    quot_x    <= '0;
                    quot_y    <= '0;
                    zero_flag <= (op_p == '0);
                    cnt       <= CNT_LAST;
                    state     <= S_ITER;
                end
                S_ITER: begin
                    rem_x  <= rem_x_nxt;
                    rem_y  <= rem_y_nxt;
                    quot_x <= {quot_x[N-2:0], ge_x};
                    quot_y <= {quot_y[N-2:0], ge_y};
                    dvd_x  <= dvd_x << 1;
                    dvd_y  <= dvd_y << 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FINISH;
                end
                S_FINISH: begin
                    ux_quot     <= zero_flag ? '0 : apply_sign(quot_x, sx);
                    uy_quot     <= zero_flag ? '0 : apply_sign(quot_y, sy);
                    div_by_zero <= zero_flag;
                    div_valid   <= 1'b1;
                    div_busy    <= 1'b0;
                    state       <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
